// File: rtl/sa_matmul_sequencer.sv
// Sequencer for a SIZE x SIZE weight-stationary systolic array: loads B, streams skewed A, collects C.
// Latency: outputs registered; LOAD_W from cycle 1 after start, STREAM next, DRAIN until all results or DRAIN_MAX.
// Backpressure: none; start is ignored unless IDLE, beats outside STREAM/DRAIN or past SIZE per column are dropped.
// Ports: start/busy job handshake; a_flat/b_flat operands; weight_out/weight_load/shift_en weight feed;
//        row_data_out/row_valid skewed A feed; col_sum_in/col_valid_in bottom-row results;
//        c_flat captured C; done/timeout one-cycle completion pulses.
module sa_matmul_sequencer #(
  parameter int DATA_WIDTH = 4,
  parameter int ACC_WIDTH  = 9,
  parameter int SIZE       = 2,
  parameter int DRAIN_MAX  = 15
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                start,
  output logic                                busy,
  input  logic [SIZE*SIZE*DATA_WIDTH-1:0]     a_flat,
  input  logic [SIZE*SIZE*DATA_WIDTH-1:0]     b_flat,
  output logic [SIZE*DATA_WIDTH-1:0]          weight_out,
  output logic                                weight_load,
  output logic                                shift_en,
  output logic [SIZE*DATA_WIDTH-1:0]          row_data_out,
  output logic [SIZE-1:0]                     row_valid,
  input  logic [SIZE*ACC_WIDTH-1:0]           col_sum_in,
  input  logic [SIZE-1:0]                     col_valid_in,
  output logic [SIZE*SIZE*ACC_WIDTH-1:0]      c_flat,
  output logic                                done,
  output logic                                timeout
);

  localparam int MAXCNT = (2*SIZE > DRAIN_MAX) ? 2*SIZE : DRAIN_MAX;
  localparam int CW     = $clog2(MAXCNT + 1);
  localparam int BW     = $clog2(SIZE + 1);

  localparam logic [CW-1:0] LOAD_LAST   = CW'(SIZE - 1);
  localparam logic [CW-1:0] STREAM_LAST = CW'(2*SIZE - 2);
  localparam logic [CW-1:0] DRAIN_LAST  = CW'(DRAIN_MAX - 1);
  localparam logic [BW-1:0] BEATS       = BW'(SIZE);
  localparam logic [BW-1:0] BEATS_M1    = BW'(SIZE - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    STREAM,
    DRAIN,
    FINISH
  } state_t;

  state_t                            state, state_nxt;
  logic [CW-1:0]                     step, step_nxt;
  logic [SIZE*SIZE*DATA_WIDTH-1:0]   a_reg, b_reg, a_nxt, b_nxt;
  logic [BW-1:0]                     beat_cnt [SIZE];
  logic [SIZE-1:0]                   hit;
  logic                              accept, capture_en, all_in;
  logic                              done_nxt, timeout_nxt, busy_nxt, load_nxt;
  logic [SIZE*DATA_WIDTH-1:0]        weight_nxt, row_data_nxt;
  logic [SIZE-1:0]                   row_valid_nxt;

  assign accept     = (state == IDLE) && start;
  assign capture_en = (state == STREAM) || (state == DRAIN);

  // Operands as they will be after this edge, so registered outputs can
  // present the first weight row in the very first LOAD_W cycle.
  assign a_nxt = accept ? a_flat : a_reg;
  assign b_nxt = accept ? b_flat : b_reg;

  // A column is complete if it already holds SIZE beats or takes its last one now.
  always_comb begin
    all_in = 1'b1;
    hit    = '0;
    for (int j = 0; j < SIZE; j++) begin
      hit[j] = capture_en && col_valid_in[j] && (beat_cnt[j] != BEATS);
      if (!((beat_cnt[j] == BEATS) || (hit[j] && (beat_cnt[j] == BEATS_M1))))
        all_in = 1'b0;
    end
  end

  always_comb begin
    state_nxt   = state;
    step_nxt    = step;
    done_nxt    = 1'b0;
    timeout_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = LOAD_W;
          step_nxt  = '0;
        end
      end
      LOAD_W: begin
        if (step == LOAD_LAST) begin
          state_nxt = STREAM;
          step_nxt  = '0;
        end else begin
          step_nxt = step + 1'b1;
        end
      end
      STREAM: begin
        if (step == STREAM_LAST) begin
          state_nxt = DRAIN;
          step_nxt  = '0;
        end else begin
          step_nxt = step + 1'b1;
        end
      end
      DRAIN: begin
        // Completion is tested before expiry so a last beat on the final
        // permitted cycle still reports done.
        if (all_in) begin
          state_nxt = FINISH;
          done_nxt  = 1'b1;
        end else if (step == DRAIN_LAST) begin
          state_nxt   = FINISH;
          timeout_nxt = 1'b1;
        end else begin
          step_nxt = step + 1'b1;
        end
      end
      FINISH: begin
        state_nxt = IDLE;
        step_nxt  = '0;
      end
      default: begin
        state_nxt = IDLE;
        step_nxt  = '0;
      end
    endcase
  end

  assign busy_nxt = (state_nxt == LOAD_W) || (state_nxt == STREAM) || (state_nxt == DRAIN);
  assign load_nxt = (state_nxt == LOAD_W);

  // Weights go in bottom row first; A enters row k delayed by k cycles.
  always_comb begin
    weight_nxt    = '0;
    row_data_nxt  = '0;
    row_valid_nxt = '0;
    if (state_nxt == LOAD_W) begin
      for (int j = 0; j < SIZE; j++)
        weight_nxt[j*DATA_WIDTH +: DATA_WIDTH] =
          b_nxt[((SIZE - 1 - int'(step_nxt))*SIZE + j)*DATA_WIDTH +: DATA_WIDTH];
    end
    if (state_nxt == STREAM) begin
      for (int k = 0; k < SIZE; k++) begin
        if ((int'(step_nxt) >= k) && (int'(step_nxt) - k < SIZE)) begin
          row_valid_nxt[k] = 1'b1;
          row_data_nxt[k*DATA_WIDTH +: DATA_WIDTH] =
            a_nxt[((int'(step_nxt) - k)*SIZE + k)*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      step         <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      c_flat       <= '0;
      busy         <= 1'b0;
      weight_out   <= '0;
      weight_load  <= 1'b0;
      shift_en     <= 1'b0;
      row_data_out <= '0;
      row_valid    <= '0;
      done         <= 1'b0;
      timeout      <= 1'b0;
      for (int j = 0; j < SIZE; j++)
        beat_cnt[j] <= '0;
    end else begin
      state        <= state_nxt;
      step         <= step_nxt;
      a_reg        <= a_nxt;
      b_reg        <= b_nxt;
      busy         <= busy_nxt;
      weight_out   <= weight_nxt;
      weight_load  <= load_nxt;
      shift_en     <= load_nxt;
      row_data_out <= row_data_nxt;
      row_valid    <= row_valid_nxt;
      done         <= done_nxt;
      timeout      <= timeout_nxt;
      if (accept) begin
        c_flat <= '0;
        for (int j = 0; j < SIZE; j++)
          beat_cnt[j] <= '0;
      end else begin
        // n-th beat on column j lands in C[n][j]
        for (int j = 0; j < SIZE; j++) begin
          if (hit[j]) begin
            c_flat[(int'(beat_cnt[j])*SIZE + j)*ACC_WIDTH +: ACC_WIDTH] <=
              col_sum_in[j*ACC_WIDTH +: ACC_WIDTH];
            beat_cnt[j] <= beat_cnt[j] + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sa_matmul_sequencer.sv
module tb_sa_matmul_sequencer;
  localparam int DW = 4;
  localparam int AW = 9;
  localparam int N  = 2;
  localparam int DM = 15;
  localparam int DRAIN_START = 3*N;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic                 start = 1'b0;
  logic [N*N*DW-1:0]    a_flat = '0;
  logic [N*N*DW-1:0]    b_flat = '0;
  logic [N*AW-1:0]      col_sum_in = '0;
  logic [N-1:0]         col_valid_in = '0;
  logic                 busy, weight_load, shift_en, done, timeout;
  logic [N*DW-1:0]      weight_out, row_data_out;
  logic [N-1:0]         row_valid;
  logic [N*N*AW-1:0]    c_flat;

  int total = 0;
  int bad   = 0;

  // Reference-model state: weights seen in the array, partial sums per
  // (result row, column), cycle each result beat is emitted (-1 = never).
  int wmat  [N][N];
  int psum  [N][N];
  int bt    [N][N];
  int rcount[N];

  always #5 clk = ~clk;

  sa_matmul_sequencer #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .SIZE(N), .DRAIN_MAX(DM)) dut (
    .clk(clk), .rstn(rstn), .start(start), .busy(busy),
    .a_flat(a_flat), .b_flat(b_flat),
    .weight_out(weight_out), .weight_load(weight_load), .shift_en(shift_en),
    .row_data_out(row_data_out), .row_valid(row_valid),
    .col_sum_in(col_sum_in), .col_valid_in(col_valid_in),
    .c_flat(c_flat), .done(done), .timeout(timeout)
  );

  function automatic int el(input logic [N*N*DW-1:0] m, input int r, input int c);
    return int'(m[(r*N + c)*DW +: DW]);
  endfunction

  function automatic int cel(input logic [N*N*AW-1:0] m, input int r, input int c);
    return int'(m[(r*N + c)*AW +: AW]);
  endfunction

  // Runs one job starting in an IDLE cycle; returns in the IDLE cycle after FINISH.
  // abort_at > 0 pulls reset at that cycle and returns with reset released.
  task automatic run_job(input logic [N*N*DW-1:0] a, input logic [N*N*DW-1:0] b,
                         input int lat, input bit drop, input bit extra, input bit stray,
                         input int alt_at, input logic [N*N*DW-1:0] a_alt,
                         input int abort_at, input string nm,
                         output int fin, output bit got_done);
    int cyc, last, exp_fin, ev, ex, sum;
    bit exp_done, deliv;
    for (int i = 0; i < N; i++) begin
      rcount[i] = 0;
      for (int j = 0; j < N; j++) begin
        wmat[i][j] = 0; psum[i][j] = 0; bt[i][j] = -1;
      end
    end
    fin = 0; got_done = 1'b0;
    a_flat = a; b_flat = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; cyc = 1;
    while (fin == 0 && cyc < 200) begin
      if (cyc == abort_at) begin
        col_valid_in = '0;
        rstn = 1'b0;
        #1;
        total++;
        if ({busy, weight_load, shift_en, done, timeout} !== 5'b0 || weight_out !== '0 ||
            row_data_out !== '0 || row_valid !== '0 || c_flat !== '0) begin
          bad++;
          $display("FAIL %s abort_outputs: busy=%b wl=%b se=%b w=%h rd=%h rv=%b c=%h done=%b to=%b, required all zero",
                   nm, busy, weight_load, shift_en, weight_out, row_data_out, row_valid, c_flat, done, timeout);
        end
        for (int n = 0; n < 4; n++) begin
          @(posedge clk); #1;
          total++;
          if (done !== 1'b0 || timeout !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s abort_quiet: done=%b timeout=%b busy=%b, required 0 0 0", nm, done, timeout, busy);
          end
        end
        rstn = 1'b1;
        @(posedge clk); #1;
        fin = -1;
        return;
      end
      start = (cyc == alt_at);
      if (cyc == alt_at) a_flat = a_alt;
      // weight feed
      if (cyc >= 1 && cyc <= N) begin
        total++;
        if (weight_load !== 1'b1 || shift_en !== 1'b1) begin
          bad++;
          $display("FAIL %s load_strobes cyc=%0d: wl=%b se=%b, required 1 1", nm, cyc, weight_load, shift_en);
        end
        for (int j = 0; j < N; j++) begin
          total++;
          if (int'(weight_out[j*DW +: DW]) !== el(b, N-1-(cyc-1), j)) begin
            bad++;
            $display("FAIL %s weight cyc=%0d col=%0d: got %0d, required %0d",
                     nm, cyc, j, weight_out[j*DW +: DW], el(b, N-1-(cyc-1), j));
          end
        end
      end else begin
        total++;
        if (weight_load !== 1'b0 || shift_en !== 1'b0 || weight_out !== '0) begin
          bad++;
          $display("FAIL %s load_idle cyc=%0d: wl=%b se=%b w=%h, required 0 0 0", nm, cyc, weight_load, shift_en, weight_out);
        end
      end
      // skewed A feed
      for (int k = 0; k < N; k++) begin
        int t;
        bit ev_v;
        t = cyc - (N + 1);
        ev_v = (cyc > N) && (cyc <= 3*N - 1) && (t - k >= 0) && (t - k < N);
        ev = ev_v ? el(a, t - k, k) : 0;
        total++;
        if (row_valid[k] !== ev_v || int'(row_data_out[k*DW +: DW]) !== ev) begin
          bad++;
          $display("FAIL %s row cyc=%0d row=%0d: valid=%b data=%0d, required valid=%b data=%0d",
                   nm, cyc, k, row_valid[k], row_data_out[k*DW +: DW], ev_v, ev);
        end
      end
      // array model: weights shift down on shift_en, row beats accumulate products
      if (shift_en === 1'b1) begin
        for (int j = 0; j < N; j++) begin
          for (int k = N-1; k > 0; k--) wmat[k][j] = wmat[k-1][j];
          wmat[0][j] = int'(weight_out[j*DW +: DW]);
        end
      end
      for (int k = 0; k < N; k++) begin
        if (row_valid[k] === 1'b1 && rcount[k] < N) begin
          int i;
          i = rcount[k];
          rcount[k]++;
          for (int j = 0; j < N; j++) psum[i][j] += int'(row_data_out[k*DW +: DW]) * wmat[k][j];
          if (k == N-1)
            for (int j = 0; j < N; j++)
              if (!(drop && i == N-1 && j == N-1)) bt[i][j] = cyc + lat + j;
        end
      end
      // handshake
      if (done === 1'b1 || timeout === 1'b1) begin
        fin = cyc;
        got_done = (done === 1'b1);
        total++;
        if (busy !== 1'b0 || (done === 1'b1 && timeout === 1'b1)) begin
          bad++;
          $display("FAIL %s finish_flags cyc=%0d: busy=%b done=%b timeout=%b, required busy=0 and one pulse",
                   nm, cyc, busy, done, timeout);
        end
      end else begin
        total++;
        if (busy !== 1'b1) begin
          bad++;
          $display("FAIL %s busy cyc=%0d: got %b, required 1", nm, cyc, busy);
        end
      end
      // result beats for this cycle, garbage sums when not valid
      col_valid_in = '0;
      for (int j = 0; j < N; j++) begin
        col_sum_in[j*AW +: AW] = AW'($urandom);
        for (int i = 0; i < N; i++)
          if (bt[i][j] == cyc) begin
            col_valid_in[j] = 1'b1;
            col_sum_in[j*AW +: AW] = AW'(psum[i][j]);
          end
      end
      if (extra && bt[N-1][0] >= 0 && cyc == bt[N-1][0] + 1) begin
        col_valid_in[0] = 1'b1;
        col_sum_in[0 +: AW] = AW'($urandom);
      end
      if (stray && cyc == 1) begin
        col_valid_in = '1;
        col_sum_in = (N*AW)'($urandom);
      end
      @(posedge clk); #1;
      cyc++;
    end
    col_valid_in = '0;
    start = 1'b0;
    if (fin == 0) begin
      bad++; total++;
      $display("FAIL %s watchdog: no done/timeout within 200 cycles, required one", nm);
      return;
    end
    // expected completion from delivered beats
    last = 0; deliv = 1'b1;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        if (bt[i][j] < 0) deliv = 1'b0;
        else if (bt[i][j] > last) last = bt[i][j];
      end
    if (last < DRAIN_START) last = DRAIN_START;
    exp_done = deliv && (last <= DRAIN_START + DM - 1);
    exp_fin  = exp_done ? last + 1 : DRAIN_START + DM;
    total++;
    if (fin !== exp_fin || got_done !== exp_done) begin
      bad++;
      $display("FAIL %s finish_cycle: cycle=%0d done=%b, required cycle=%0d done=%b", nm, fin, got_done, exp_fin, exp_done);
    end
    // now in the IDLE cycle after FINISH: pulses gone, C held
    total++;
    if (done !== 1'b0 || timeout !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s post_finish: done=%b timeout=%b busy=%b, required 0 0 0", nm, done, timeout, busy);
    end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        sum = 0;
        for (int k = 0; k < N; k++) sum += el(a, i, k) * el(b, k, j);
        ex = (bt[i][j] >= 0 && bt[i][j] < fin) ? (sum & ((1 << AW) - 1)) : 0;
        total++;
        if (cel(c_flat, i, j) !== ex) begin
          bad++;
          $display("FAIL %s c[%0d][%0d]: got %0d, required %0d", nm, i, j, cel(c_flat, i, j), ex);
        end
      end
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({busy, weight_load, shift_en, done, timeout} !== 5'b0 || weight_out !== '0 ||
        row_data_out !== '0 || row_valid !== '0 || c_flat !== '0) begin
      bad++;
      $display("FAIL reset_values: busy=%b wl=%b se=%b w=%h rd=%h rv=%b c=%h done=%b to=%b, required all zero",
               busy, weight_load, shift_en, weight_out, row_data_out, row_valid, c_flat, done, timeout);
    end
    rstn = 1'b1;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: busy=%b without start, required 0", busy);
    end
  endtask

  task automatic test_basic;
    int f; bit d;
    run_job(16'h4321, 16'h8765, 2, 0, 0, 0, 0, '0, 0, "basic", f, d);
    total++;
    if (cel(c_flat,0,0) !== 19 || cel(c_flat,0,1) !== 22 || cel(c_flat,1,0) !== 43 || cel(c_flat,1,1) !== 50) begin
      bad++;
      $display("FAIL basic_const: C=[[%0d,%0d],[%0d,%0d]], required [[19,22],[43,50]]",
               cel(c_flat,0,0), cel(c_flat,0,1), cel(c_flat,1,0), cel(c_flat,1,1));
    end
  endtask

  task automatic test_timeout;
    int f; bit d;
    run_job(16'h4321, 16'h8765, 2, 1, 0, 0, 0, '0, 0, "timeout", f, d);
    total++;
    if (f !== DRAIN_START + DM || d !== 1'b0 || cel(c_flat,0,1) !== 22 || cel(c_flat,1,1) !== 0) begin
      bad++;
      $display("FAIL timeout_const: cycle=%0d done=%b c01=%0d c11=%0d, required cycle=%0d done=0 c01=22 c11=0",
               f, d, cel(c_flat,0,1), cel(c_flat,1,1), DRAIN_START + DM);
    end
  endtask

  task automatic test_start_while_busy;
    int f; bit d;
    run_job(16'h4321, 16'h8765, 2, 0, 0, 0, 3, 16'h1111, 0, "start_busy", f, d);
  endtask

  task automatic test_back_to_back;
    int f; bit d;
    run_job(16'h1234, 16'h4321, 1, 0, 0, 0, 0, '0, 0, "b2b_first", f, d);
    run_job(16'h9A5C, 16'h3E71, 3, 0, 0, 0, 0, '0, 0, "b2b_second", f, d);
  endtask

  task automatic test_reset_mid;
    int f; bit d;
    run_job(16'h4321, 16'h8765, 2, 0, 0, 0, 0, '0, 4, "reset_mid", f, d);
    run_job(16'h2468, 16'h1357, 2, 0, 0, 0, 0, '0, 0, "after_reset", f, d);
  endtask

  task automatic test_max;
    int f; bit d;
    run_job(16'hFFFF, 16'hFFFF, 2, 0, 1, 1, 0, '0, 0, "max", f, d);
    total++;
    if (cel(c_flat,0,0) !== 450 || cel(c_flat,0,1) !== 450 || cel(c_flat,1,0) !== 450 || cel(c_flat,1,1) !== 450) begin
      bad++;
      $display("FAIL max_const: C=[[%0d,%0d],[%0d,%0d]], required all 450",
               cel(c_flat,0,0), cel(c_flat,0,1), cel(c_flat,1,0), cel(c_flat,1,1));
    end
  endtask

  task automatic test_random;
    int f; bit d;
    for (int r = 0; r < 10; r++)
      run_job(16'($urandom), 16'($urandom), int'($urandom_range(1, 4)),
              ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
              0, '0, 0, "random", f, d);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    test_max();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sa_matmul_sequencer.md
# sa_matmul_sequencer

Sequencer for the SIZE×SIZE weight-stationary systolic array built from the team's processing elements. It accepts one matrix-multiply job (A·B) through a start/busy handshake and loads B into the array. It then streams A into the array rows with diagonal skew, collects the bottom-row column results into C and signals done, or signals timeout if the array under-delivers. It sits between the host register block and the PE grid and owns every PE control strobe (in_valid, shift_en, weight feed).

## Interface
- DATA_WIDTH, 4, operand width of A and B elements
- ACC_WIDTH, 9, result/partial-sum width
- SIZE, 2, array dimension (rows = columns = SIZE)
- DRAIN_MAX, 15, max cycles to wait for results after the last row beat
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- start  in  1  job request; accepted only in IDLE
- busy  out  1  high from the cycle after acceptance until done/timeout
- a_flat  in  SIZE*SIZE*DATA_WIDTH  A[i][k] at bit offset (i*SIZE+k)*DATA_WIDTH
- b_flat  in  SIZE*SIZE*DATA_WIDTH  B[k][j], same packing
- weight_out  out  SIZE*DATA_WIDTH  weight for column j at offset j*DATA_WIDTH
- weight_load  out  1  weight_out is valid this cycle
- shift_en  out  1  PE weight-shift strobe
- row_data_out  out  SIZE*DATA_WIDTH  operand for array row k at offset k*DATA_WIDTH
- row_valid  out  SIZE  per-row in_valid
- col_sum_in  in  SIZE*ACC_WIDTH  bottom-row partial sum, column j
- col_valid_in  in  SIZE  bottom-row out_valid, column j
- c_flat  out  SIZE*SIZE*ACC_WIDTH  C[i][j] at offset (i*SIZE+j)*ACC_WIDTH
- done  out  1  one-cycle pulse: all results captured
- timeout  out  1  one-cycle pulse: DRAIN_MAX expired before all results arrived

## Operation
- States: IDLE, LOAD_W, STREAM, DRAIN, FINISH.
- IDLE: start=1 at a clock edge latches a_flat/b_flat, clears c_flat and per-column beat counters, moves to LOAD_W. start is ignored in all other states.
- LOAD_W: runs SIZE cycles, t=0..SIZE-1. Drives weight_out[j]=B[SIZE-1-t][j], weight_load=1, shift_en=1, row_valid=0. Then moves to STREAM.
- STREAM: runs 2*SIZE-1 cycles, t=0..2*SIZE-2. For row k, if 0≤t-k<SIZE, drive row_data_out[k]=A[t-k][k] and row_valid[k]=1. Otherwise drive row_data_out[k]=0 and row_valid[k]=0. shift_en=0, weight_load=0. Then moves to DRAIN.
- Capture runs in STREAM and DRAIN. The n-th col_valid_in[j] beat (n=0..SIZE-1) writes col_sum_in[j] into C[n][j]. Beats after the SIZE-th on a column are ignored. Beats in IDLE, LOAD_W and FINISH are ignored.
- DRAIN: a counter starts at 0. When all columns have SIZE beats (a beat in the current cycle counts), move to FINISH with done. If the counter reaches DRAIN_MAX first, move to FINISH with timeout. Partial C is retained.
- FINISH: one cycle, done or timeout=1, busy=0, then IDLE.
- No arithmetic is performed; C is stored verbatim at ACC_WIDTH bits.
- c_flat holds its value from FINISH until the next accepted start.

## Timing
- All outputs are registered and driven from the current state and step counter.
- Reset value of every output is 0: busy, weight_out, weight_load, shift_en, row_data_out, row_valid, c_flat, done, timeout. State resets to IDLE.
- Reset asserted mid-job aborts immediately. All outputs go to 0 asynchronously; no done or timeout is issued.
- Cycle map, start sampled at edge 0:
  - LOAD_W occupies cycles 1..SIZE.
  - STREAM occupies cycles SIZE+1..3*SIZE-1.
  - DRAIN follows.
  - For SIZE=2: LOAD_W is cycles 1–2, STREAM is cycles 3–5, DRAIN starts at cycle 6.
- busy=1 from cycle 1 through the last DRAIN cycle.
- done and timeout are mutually exclusive.
- If the final beat arrives on the last permitted DRAIN cycle (counter = DRAIN_MAX-1), done wins over timeout.
- Simultaneous beats on different columns are all captured in the same cycle.

## Test plan
- Basic multiply: A=[[1,2],[3,4]], B=[[5,6],[7,8]], behavioural array model latency 2. Required: c_flat=[[19,22],[43,50]], done at one cycle, busy falls with done, timeout=0.
- Load/skew check: same job, monitor outputs.
  - Required: cycles 1–2 weight_out = {7,8} then {5,6}, with shift_en=weight_load=1.
  - Required: cycles 3–5 row_valid = 01, 11, 10.
  - Required: row0 data 1 then 3; row1 data 2 then 4.
- Timeout: model drops column 1's second beat. Required: timeout pulse exactly DRAIN_MAX=15 cycles into DRAIN, done=0, C[0][1] captured, C[1][1]=0.
- Start while busy: pulse start at cycle 3 with different A. Required: ignored, result unchanged from the basic test. Back-to-back start in the cycle after FINISH is accepted.
- Reset mid-STREAM: rstn low at cycle 4. Required: all outputs 0 immediately, state IDLE, no done. A fresh job afterwards gives correct C.
- Max values: A and B all 15. Required: each C=450 (fits 9 bits), with extra col_valid beats ignored.
